// File: rtl/droop_det_if.sv
// Shared brake-state type and the detector's bus: sample stream and controls in,
// brake request and status out.
package droop_det_pkg;
    typedef enum logic [1:0] {
        BRAKES_OFF = 2'd0,
        BRAKING    = 2'd1,
        RECOVERING = 2'd2
    } brake_state_t;
endpackage

interface droop_det_if #(
    parameter int ERR_W = 16
);
    logic                        en;
    logic                        err_valid;
    logic signed [ERR_W-1:0]     phase_err;
    droop_det_pkg::brake_state_t brake_state;
    logic                        cnt_clr;
    logic                        brake;
    logic [1:0]                  det_state;
    logic [15:0]                 droop_count;

    modport master (
        output en, err_valid, phase_err, brake_state, cnt_clr,
        input  brake, det_state, droop_count
    );

    modport slave (
        input  en, err_valid, phase_err, brake_state, cnt_clr,
        output brake, det_state, droop_count
    );
endinterface

// File: rtl/droop_det.sv
// Supply-droop detector: qualifies TDC phase-error magnitude with hysteresis and
// consecutive-sample filters, then raises a registered brake request.
module droop_det #(
    parameter int ERR_W          = 16,
    parameter int TRIP_THRESH    = 1000,
    parameter int CLEAR_THRESH   = 250,
    parameter int TRIP_CYCLES    = 4,
    parameter int CLEAR_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic        refclk,
    input  logic        resetn,
    droop_det_if.slave  bus
);
    import droop_det_pkg::*;

    localparam int TW = $clog2(TRIP_CYCLES + 1);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [ERR_W-1:0] TRIP_T   = ERR_W'(TRIP_THRESH);
    localparam logic [ERR_W-1:0] CLEAR_T  = ERR_W'(CLEAR_THRESH);
    localparam logic [ERR_W-1:0] MAG_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] ERR_MIN  = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [TW-1:0]    TRIP_LAST = TW'(TRIP_CYCLES - 1);
    localparam logic [CW-1:0]    CLR_LAST  = CW'(CLEAR_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_INIT = HW'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t          state_q;
    logic            brake_q;
    logic [TW-1:0]   trip_cnt_q;
    logic [CW-1:0]   clr_cnt_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [15:0]     droop_cnt_q, droop_cnt_d;

    logic [ERR_W-1:0] mag;
    logic             is_droop, is_recov, trip_fire;

    // The most negative code has no positive twin, so clamp it to full scale.
    always_comb begin
        mag = bus.phase_err;
        if (bus.phase_err == ERR_MIN)
            mag = MAG_MAX;
        else if (bus.phase_err[ERR_W-1])
            mag = -bus.phase_err;
    end

    assign is_droop  = (mag >= TRIP_T);
    assign is_recov  = (mag <= CLEAR_T);
    assign trip_fire = bus.en && (state_q == ARMED) && bus.err_valid &&
                       is_droop && (trip_cnt_q == TRIP_LAST);

    // A clear landing on a trip edge still records that trip.
    always_comb begin
        droop_cnt_d = droop_cnt_q;
        if (bus.cnt_clr)
            droop_cnt_d = {15'd0, trip_fire};
        else if (trip_fire && droop_cnt_q != 16'hFFFF)
            droop_cnt_d = droop_cnt_q + 16'd1;
    end

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            brake_q     <= 1'b0;
            trip_cnt_q  <= '0;
            clr_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            droop_cnt_q <= '0;
        end else begin
            droop_cnt_q <= droop_cnt_d;
            if (!bus.en) begin
                state_q    <= IDLE;
                brake_q    <= 1'b0;
                trip_cnt_q <= '0;
                clr_cnt_q  <= '0;
                hold_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        brake_q    <= 1'b0;
                        trip_cnt_q <= '0;
                        clr_cnt_q  <= '0;
                        hold_cnt_q <= '0;
                        state_q    <= ARMED;
                    end
                    ARMED: begin
                        if (bus.err_valid) begin
                            if (trip_fire) begin
                                state_q    <= TRIPPED;
                                brake_q    <= 1'b1;
                                trip_cnt_q <= '0;
                                clr_cnt_q  <= '0;
                            end else if (is_droop)
                                trip_cnt_q <= trip_cnt_q + 1'b1;
                            else
                                trip_cnt_q <= '0;
                        end
                    end
                    TRIPPED: begin
                        brake_q <= 1'b1;
                        if (bus.err_valid) begin
                            if (is_recov && clr_cnt_q == CLR_LAST) begin
                                state_q    <= HOLDOFF;
                                brake_q    <= 1'b0;
                                clr_cnt_q  <= '0;
                                hold_cnt_q <= HOLD_INIT;
                            end else if (is_recov)
                                clr_cnt_q <= clr_cnt_q + 1'b1;
                            else
                                clr_cnt_q <= '0;
                        end
                    end
                    HOLDOFF: begin
                        // Samples are ignored here; re-arm needs both the timer and a quiet manager.
                        brake_q <= 1'b0;
                        if (hold_cnt_q != '0)
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        else if (bus.brake_state == BRAKES_OFF)
                            state_q <= ARMED;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.brake       = brake_q;
    assign bus.det_state   = state_q;
    assign bus.droop_count = droop_cnt_q;

endmodule

// File: tb/tb_droop_det.sv
// Directed bench for droop_det: trip/clear qualification, holdoff gating,
// magnitude saturation, counter clear and asynchronous reset.
module tb_droop_det;
    import droop_det_pkg::*;

    logic refclk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    droop_det_if #(.ERR_W(16)) bus ();

    droop_det #(.ERR_W(16)) dut (
        .refclk (refclk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic smp(input logic v, input logic signed [15:0] e);
        bus.err_valid = v;
        bus.phase_err = e;
        tick();
        bus.err_valid = 1'b0;
    endtask

    task automatic st(input string tag, input logic b, input logic [1:0] s, input logic [15:0] c);
        chk({tag, "_brake"}, {31'd0, bus.brake}, {31'd0, b});
        chk({tag, "_state"}, {30'd0, bus.det_state}, {30'd0, s});
        chk({tag, "_cnt"},   {16'd0, bus.droop_count}, {16'd0, c});
    endtask

    initial begin
        bus.en = 1'b0; bus.err_valid = 1'b0; bus.phase_err = '0;
        bus.brake_state = BRAKES_OFF; bus.cnt_clr = 1'b0;
        #12;
        st("reset", 1'b0, 2'd0, 16'd0);
        resetn = 1'b1;
        tick();
        st("idle_en0", 1'b0, 2'd0, 16'd0);
        bus.en = 1'b1;
        tick();
        st("armed", 1'b0, 2'd1, 16'd0);

        // four +1200: brake one edge after the 4th
        for (int i = 0; i < 3; i++) smp(1'b1, 16'sd1200);
        st("trip3", 1'b0, 2'd1, 16'd0);
        smp(1'b1, 16'sd1200);
        st("trip4", 1'b1, 2'd2, 16'd1);

        // 16 recovered samples with gaps; a droop sample in between restarts nothing here
        for (int i = 0; i < 15; i++) begin
            smp(1'b1, 16'sd100);
            smp(1'b0, 16'sd2000);
        end
        st("clr15", 1'b1, 2'd2, 16'd1);
        smp(1'b1, 16'sd100);
        st("clr16", 1'b0, 2'd3, 16'd1);

        // manager still recovering: stay in HOLDOFF; droops ignored
        bus.brake_state = RECOVERING;
        for (int i = 0; i < 200; i++) smp(1'b1, 16'sd1200);
        st("hold_recov", 1'b0, 2'd3, 16'd1);
        bus.brake_state = BRAKES_OFF;
        tick();
        st("rearm", 1'b0, 2'd1, 16'd1);

        // interrupted run does not trip
        for (int i = 0; i < 3; i++) smp(1'b1, -16'sd1500);
        smp(1'b1, 16'sd500);
        for (int i = 0; i < 3; i++) smp(1'b1, -16'sd1500);
        st("interrupt", 1'b0, 2'd1, 16'd1);
        smp(1'b1, -16'sd1500);
        st("trip_neg", 1'b1, 2'd2, 16'd2);

        // clear at exactly CLEAR_THRESH, BRAKES_OFF already: 64-cycle minimum
        for (int i = 0; i < 16; i++) smp(1'b1, -16'sd250);
        st("clr_edge", 1'b0, 2'd3, 16'd2);
        for (int i = 0; i < 64; i++) smp(1'b1, 16'sd1200);
        st("hold64", 1'b0, 2'd3, 16'd2);
        tick();
        st("hold65", 1'b0, 2'd1, 16'd2);

        // most negative code saturates and trips; clear on the trip edge keeps it
        for (int i = 0; i < 3; i++) smp(1'b1, 16'sh8000);
        bus.cnt_clr = 1'b1;
        smp(1'b1, 16'sh8000);
        bus.cnt_clr = 1'b0;
        st("sat_clr", 1'b1, 2'd2, 16'd1);

        // async reset while tripped
        resetn = 1'b0;
        #1;
        st("async_rst", 1'b0, 2'd0, 16'd0);
        #3;
        resetn = 1'b1;
        tick();
        st("rst_rel", 1'b0, 2'd1, 16'd0);

        // boundary -1000 trips; en=0 drops brake but keeps count; then clear
        for (int i = 0; i < 3; i++) smp(1'b1, 16'sd999);
        for (int i = 0; i < 3; i++) smp(1'b1, -16'sd1000);
        st("below_thr", 1'b0, 2'd1, 16'd0);
        smp(1'b1, -16'sd1000);
        st("thr_trip", 1'b1, 2'd2, 16'd1);
        bus.en = 1'b0;
        tick();
        st("en_off", 1'b0, 2'd0, 16'd1);
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        st("cnt_clr", 1'b0, 2'd0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/droop_det.md
DROOP_DET -- requirements
Module: droop_det

Interface
REQ-001 SHALL have parameter ERR_W, default 16, phase-error input width in bits.
REQ-002 SHALL have parameter TRIP_THRESH, default 1000, error magnitude at or above which a sample counts as droop.
REQ-003 SHALL have parameter CLEAR_THRESH, default 250, error magnitude at or below which a sample counts as recovered; CLEAR_THRESH < TRIP_THRESH.
REQ-004 SHALL have parameter TRIP_CYCLES, default 4, consecutive droop samples required to trip.
REQ-005 SHALL have parameter CLEAR_CYCLES, default 16, consecutive recovered samples required to release.
REQ-006 SHALL have parameter HOLDOFF_CYCLES, default 64, minimum refclk cycles in HOLDOFF before re-arming.
REQ-007 SHALL have port refclk, input, 1, the only clock.
REQ-008 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port en, input, 1, detector enable.
REQ-010 SHALL have port err_valid, input, 1, phase_err is valid this cycle.
REQ-011 SHALL have port phase_err, input, ERR_W, signed two's-complement TDC phase error.
REQ-012 SHALL have port brake_state, input, brake_state_t, state of the downstream droop manager (BRAKES_OFF / BRAKING / RECOVERING).
REQ-013 SHALL have port cnt_clr, input, 1, single-cycle pulse that clears droop_count.
REQ-014 SHALL have port brake, output, 1, registered brake request to the droop manager.
REQ-015 SHALL have port det_state, output, 2, FSM state encoded IDLE=0, ARMED=1, TRIPPED=2, HOLDOFF=3.
REQ-016 SHALL have port droop_count, output, 16, saturating count of trips.

Function
REQ-017 SHALL compute mag = |phase_err|; the most negative input SHALL saturate to 2^(ERR_W-1)-1.
REQ-018 SHALL use samples only on cycles with err_valid=1; cycles with err_valid=0 SHALL hold all qualification counters unchanged.
REQ-019 IDLE SHALL hold brake=0 and clear the trip, clear and holdoff counters; en=1 SHALL move to ARMED on the next edge.
REQ-020 ARMED SHALL handle valid samples as follows: mag >= TRIP_THRESH increments trip_cnt; mag < TRIP_THRESH clears trip_cnt to 0.
REQ-021 In ARMED, the valid sample that makes TRIP_CYCLES consecutive droop samples SHALL cause, on that edge: state TRIPPED, brake=1, trip_cnt=0, droop_count+1.
REQ-022 Brake latency SHALL be exactly one refclk edge after the qualifying sample is presented.
REQ-023 TRIPPED SHALL hold brake=1 and handle valid samples as follows: mag <= CLEAR_THRESH increments clr_cnt; otherwise clr_cnt=0.
REQ-024 In TRIPPED, the valid sample completing CLEAR_CYCLES consecutive recovered samples SHALL cause, on that edge: state HOLDOFF, brake=0, clr_cnt=0, holdoff counter loaded with HOLDOFF_CYCLES.
REQ-025 HOLDOFF SHALL hold brake=0 and decrement the holdoff counter to 0; it SHALL move to ARMED only on an edge where the counter is 0 and brake_state == BRAKES_OFF.
REQ-026 In HOLDOFF, if brake_state is not BRAKES_OFF, the FSM SHALL remain in HOLDOFF indefinitely, with the counter held at 0.
REQ-027 Droop samples arriving in HOLDOFF SHALL be ignored and SHALL NOT trip.
REQ-028 en=0 in any state SHALL force IDLE on the next edge, with brake=0 on that edge; counters SHALL clear; droop_count SHALL be retained.
REQ-029 droop_count SHALL saturate at 16'hFFFF.
REQ-030 cnt_clr SHALL set droop_count to 0.
REQ-031 cnt_clr coincident with a trip SHALL set droop_count to 1, so the event is not lost.
REQ-032 The trip_cnt and clr_cnt counters SHALL be wide enough for their parameter and SHALL never wrap.
REQ-033 brake and det_state SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-034 resetn=0 SHALL asynchronously force state IDLE, brake=0, droop_count=0 and all counters 0.
REQ-035 Reset asserted mid-trip SHALL drop brake immediately, without waiting for a clock edge.
REQ-036 After resetn deasserts, the first transition SHALL occur on a refclk edge, and only if en=1.

Verification
REQ-037 Bench SHALL cover: en=1, four consecutive valid phase_err=+1200 -> brake=1 one edge after the 4th sample, droop_count=1, det_state=2.
REQ-038 Bench SHALL cover: three valid samples of -1500, then one sample of 500, then three of -1500 -> brake stays 0 (trip_cnt reset).
REQ-039 Bench SHALL cover: tripped; 16 valid samples of 100 interleaved with err_valid=0 gaps -> brake falls after the 16th valid sample; det_state=3.
REQ-040 Bench SHALL cover: HOLDOFF with brake_state=RECOVERING for 200 cycles -> remains det_state=3; then brake_state=BRAKES_OFF -> det_state=1 on the next edge; the 64-cycle minimum is honoured when BRAKES_OFF arrives early.
REQ-041 Bench SHALL cover: phase_err=16'h8000 ×4 -> trips (mag saturated to 32767); cnt_clr on the trip edge -> droop_count=1.
REQ-042 Bench SHALL cover: resetn pulsed low while in TRIPPED -> brake=0 asynchronously, droop_count=0, det_state=0.
